nn_host_master: RTL

- Avalon-MM initiator that drives one full inference job on the accelerator's slave interface: image load, start, status poll, result readout.
- Burst-writes 196 packed pixel words, then writes the control register to start the calculation.
- Polls the status register until the calculation is done, then reads the 10 result registers.
- Sits between the local image buffer / host sequencer and the accelerator's Avalon slave port.

---
 rtl/nn_host_master.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/nn_host_master.sv
// Avalon-MM initiator that runs one accelerator inference job: pixel burst,
// control write, status polling and result readout.
module nn_host_master #(
    parameter int unsigned PIX_WORDS    = 196,
    parameter int unsigned NUM_RESULTS  = 10,
    parameter int unsigned RESULT_BASE  = 4116,
    parameter int unsigned CONTROL_ADDR = 4126,
    parameter int unsigned STATUS_ADDR  = 4127,
    parameter logic [31:0] START_VAL    = 32'h0000_000F,
    parameter int unsigned POLL_GAP     = 8,
    parameter int unsigned MAX_POLLS    = 1024
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    output logic [7:0]  pix_addr,
    input  logic [31:0] pix_rdata,
    output logic [12:0] address,
    output logic        write,
    output logic        read,
    output logic        beginbursttransfer,
    output logic [9:0]  burstcount,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    input  logic        waitrequest,
    input  logic [1:0]  response,
    input  logic        writeresponsevalid,
    output logic        result_valid,
    output logic [3:0]  result_index,
    output logic [16:0] result_data,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int unsigned GAP_W  = $clog2(POLL_GAP + 1);
    localparam int unsigned POLL_W = $clog2(MAX_POLLS + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_BURST, S_CTRL, S_CTRL_RESP, S_POLL, S_POLL_WAIT,
        S_POLL_GAP, S_RES, S_RES_WAIT, S_FIN, S_ERR
    } state_t;

    state_t state, next_state;

    logic [GAP_W-1:0]  gap_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic [3:0]        res_idx;
    logic accepted, last_beat, last_result, poll_limit, gap_done;
    logic rd_err, wr_err;
    logic unused_readdata;

    assign accepted        = (write | read) & ~waitrequest;
    assign last_beat       = pix_addr == 8'(PIX_WORDS - 1);
    assign last_result     = res_idx == 4'(NUM_RESULTS - 1);
    assign poll_limit      = poll_cnt == POLL_W'(MAX_POLLS - 1);
    assign gap_done        = gap_cnt == GAP_W'(POLL_GAP - 1);
    assign rd_err          = response == 2'b11;
    assign wr_err          = response != 2'b00;
    assign unused_readdata = ^readdata[31:17];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= next_state;
    end

    // Read data may return in the same cycle the read is still asserted,
    // so the request states also watch readdatavalid.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (start) next_state = S_BURST;
            S_BURST: if (accepted && last_beat) next_state = S_CTRL;
            S_CTRL, S_CTRL_RESP: begin
                if ((state == S_CTRL_RESP || accepted) && writeresponsevalid)
                    next_state = wr_err ? S_ERR : S_POLL;
                else if (state == S_CTRL && accepted)
                    next_state = S_CTRL_RESP;
            end
            S_POLL, S_POLL_WAIT: begin
                if (readdatavalid) begin
                    if (rd_err)           next_state = S_ERR;
                    else if (readdata[0]) next_state = S_RES;
                    else if (poll_limit)  next_state = S_ERR;
                    else                  next_state = S_POLL_GAP;
                end else if (state == S_POLL && accepted) begin
                    next_state = S_POLL_WAIT;
                end
            end
            S_POLL_GAP: if (gap_done) next_state = S_POLL;
            S_RES, S_RES_WAIT: begin
                if (readdatavalid) begin
                    if (rd_err)           next_state = S_ERR;
                    else if (last_result) next_state = S_FIN;
                    else                  next_state = S_RES;
                end else if (state == S_RES && accepted) begin
                    next_state = S_RES_WAIT;
                end
            end
            S_FIN:   next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        write              = 1'b0;
        read               = 1'b0;
        address            = '0;
        beginbursttransfer = 1'b0;
        burstcount         = '0;
        writedata          = '0;
        done               = 1'b0;
        busy               = state != S_IDLE;
        unique case (state)
            S_BURST: begin
                write     = 1'b1;
                writedata = pix_rdata;
                if (pix_addr == '0) begin
                    beginbursttransfer = 1'b1;
                    burstcount         = 10'(PIX_WORDS);
                end
            end
            S_CTRL: begin
                write     = 1'b1;
                address   = 13'(CONTROL_ADDR);
                writedata = START_VAL;
            end
            S_POLL: begin
                read    = 1'b1;
                address = 13'(STATUS_ADDR);
            end
            S_RES: begin
                read    = 1'b1;
                address = 13'(RESULT_BASE) + 13'(res_idx);
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pix_addr     <= '0;
            gap_cnt      <= '0;
            poll_cnt     <= '0;
            res_idx      <= '0;
            result_valid <= 1'b0;
            result_index <= '0;
            result_data  <= '0;
            error        <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                S_IDLE: if (start) begin
                    pix_addr <= '0;
                    poll_cnt <= '0;
                    res_idx  <= '0;
                    error    <= 1'b0;
                end
                S_BURST: if (accepted && !last_beat) pix_addr <= pix_addr + 8'd1;
                S_POLL, S_POLL_WAIT: if (readdatavalid) begin
                    poll_cnt <= poll_cnt + 1'b1;
                    gap_cnt  <= '0;
                end
                S_POLL_GAP: gap_cnt <= gap_cnt + 1'b1;
                S_RES, S_RES_WAIT: if (readdatavalid && !rd_err) begin
                    result_valid <= 1'b1;
                    result_index <= res_idx;
                    result_data  <= readdata[16:0];
                    res_idx      <= res_idx + 4'd1;
                end
                S_ERR:   error <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule
